// File: rtl/afc_freq_comparator.sv
// afc_freq_comparator: counts divclk edges per refclk window and flags high/low/lock; optional ARM timeout via AFC_CMP_TIMEOUT_EN
module afc_freq_comparator #(
  parameter int CNT_W       = 12,
  parameter int TARGET      = 100,
  parameter int TOL         = 2,
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             afctrigger,
  input  logic             refclk,
  input  logic             divclk,
  output logic [CNT_W-1:0] count_out,
  output logic             freq_high,
  output logic             freq_low,
  output logic             freq_lock,
  output logic             meas_done,
  output logic             busy,
  output logic             timeout
);
  typedef enum logic [2:0] {IDLE, ARM, COUNT, COMPARE, DONE} state_t;
  localparam logic [CNT_W:0] HI_LIM = (CNT_W+1)'(TARGET + TOL);
  localparam logic [CNT_W:0] LO_LIM = (CNT_W+1)'(TARGET > TOL ? TARGET - TOL : 0);
  state_t state, state_d;
  logic div_s1, div_s2, div_s3, ref_q;
  logic div_rise, ref_rise, ref_fall, is_high, is_low;
  logic [CNT_W-1:0] cnt;
  logic ovf;
  assign div_rise  = div_s2 & ~div_s3;
  assign ref_rise  = refclk & ~ref_q;
  assign ref_fall  = ~refclk & ref_q;
  assign is_high   = ovf || ({1'b0, cnt} > HI_LIM);
  assign is_low    = !is_high && ({1'b0, cnt} < LO_LIM);
  assign meas_done = state == DONE;
  assign busy      = state != IDLE;
  // divclk synchronizer plus edge-detect stage, and refclk edge register
  always_ff @(posedge clk or posedge rst)
    if (rst) {div_s3, div_s2, div_s1, ref_q} <= '0;
    else {div_s3, div_s2, div_s1, ref_q} <= {div_s2, div_s1, divclk, refclk};
  // state register
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else state <= state_d;
  // saturating window edge counter, only live while a window is open
  always_ff @(posedge clk or posedge rst)
    if (rst) {cnt, ovf} <= '0;
    else if (state != COUNT) {cnt, ovf} <= '0;
    else if (div_rise) begin
      if (&cnt) ovf <= 1'b1;
      else cnt <= cnt + 1'b1;
    end
  // capture the window result; held until the next comparison
  always_ff @(posedge clk or posedge rst)
    if (rst) {count_out, freq_high, freq_low, freq_lock} <= '0;
    else if (state == COMPARE) {count_out, freq_high, freq_low, freq_lock} <= {cnt, is_high, is_low, !is_high && !is_low};
`ifdef AFC_CMP_TIMEOUT_EN
  localparam int AW = $clog2(TIMEOUT_CYC + 1);
  logic [AW-1:0] arm_cnt;
  // cycles spent waiting in ARM; restarts on every ARM entry
  always_ff @(posedge clk or posedge rst)
    if (rst) arm_cnt <= '0;
    else arm_cnt <= (state == ARM) ? arm_cnt + 1'b1 : '0;
`else
  assign timeout = (TIMEOUT_CYC < 0);
`endif
  // next-state logic; dropping afctrigger aborts any pending measurement
  always_comb begin
    state_d = state;
    case (state)
      IDLE:    state_d = afctrigger ? ARM : IDLE;
      ARM:     state_d = !afctrigger ? IDLE : ref_rise ? COUNT : ARM;
      COUNT:   state_d = !afctrigger ? IDLE : ref_fall ? COMPARE : COUNT;
      COMPARE: state_d = DONE;
      DONE:    state_d = afctrigger ? ARM : IDLE;
      default: state_d = IDLE;
    endcase
`ifdef AFC_CMP_TIMEOUT_EN
    timeout = (state == ARM) && afctrigger && !ref_rise && (arm_cnt == AW'(TIMEOUT_CYC - 1));
    state_d = timeout ? IDLE : state_d;
`endif
  end
endmodule

// File: tb/tb_afc_freq_comparator.sv
// tb_afc_freq_comparator: directed windows checked against a count/classify model of the comparator
module tb_afc_freq_comparator;
  logic clk = 0, rst = 1, trig = 0, trig4 = 0, refclk = 0, divclk = 0;
  always #5 clk = ~clk;
  logic [11:0] count_out;
  logic fh, fl, fk, done, busy, tmo;
  logic [3:0] count4;
  logic fh4, fl4, fk4, done4, busy4, tmo4;
  int tests = 0, fails = 0, done_cnt = 0;
  logic [14:0] held = '0;
  logic [14:0] exp_q[$];

  afc_freq_comparator dut (
    .clk(clk), .rst(rst), .afctrigger(trig), .refclk(refclk), .divclk(divclk),
    .count_out(count_out), .freq_high(fh), .freq_low(fl), .freq_lock(fk),
    .meas_done(done), .busy(busy), .timeout(tmo));

  afc_freq_comparator #(.CNT_W(4), .TIMEOUT_CYC(16)) dut4 (
    .clk(clk), .rst(rst), .afctrigger(trig4), .refclk(refclk), .divclk(divclk),
    .count_out(count4), .freq_high(fh4), .freq_low(fl4), .freq_lock(fk4),
    .meas_done(done4), .busy(busy4), .timeout(tmo4));

  // expected {count, high, low, lock} for a window of n edges, 12-bit counter, 100 +/- 2
  function automatic logic [14:0] predict(input int n);
    int c;
    logic h, l;
    c = (n > 4095) ? 4095 : n;
    h = (n > 4095) || (n > 102);
    l = !h && (n < 98);
    return {c[11:0], h, l, !h && !l};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // every cycle: results must equal the last predicted window; meas_done only when one is pending
  always @(negedge clk) begin
    if (exp_q.size() == 0) chk("spurious_meas_done", 32'(done), 0);
    else if (done) begin
      held = exp_q.pop_front();
      done_cnt++;
    end
    chk("held_results", 32'({count_out, fh, fl, fk}), 32'(held));
  end

  task automatic pulses(input int n);
    for (int i = 0; i < n; i++) begin
      divclk = 0;
      repeat (2) @(negedge clk);
      divclk = 1;
      repeat (2) @(negedge clk);
    end
  endtask

  // refclk window of n divclk edges; refclk falls 'tail' cycles after the last divclk rise
  task automatic window(input int n, input int tail);
    @(negedge clk);
    refclk = 1;
    pulses(n);
    repeat (tail - 2) @(negedge clk);
    refclk = 0;
    divclk = 0;
  endtask

  task automatic wait_done(input int prev);
    int k = 0;
    while (done_cnt == prev && k < 300) begin
      @(negedge clk);
      #1;
      k++;
    end
    chk("meas_done_seen", 32'(done_cnt != prev), 1);
  endtask

  task automatic measure(input int n, input int tail);
    int p = done_cnt;
    exp_q.push_back(predict(n));
    window(n, tail);
    wait_done(p);
    repeat (2) @(negedge clk);
  endtask

  initial begin
    int p;
    int k;
    repeat (3) @(negedge clk);
    chk("reset_outputs", 32'({count_out, fh, fl, fk, done, busy, tmo}), 0);
    chk("reset_outputs4", 32'({count4, fh4, fl4, fk4, done4, busy4, tmo4}), 0);
    rst = 0;
    trig = 1;
    @(negedge clk);
    chk("busy_in_arm", 32'(busy), 1);
    measure(100, 6);
    chk("nominal_count", 32'(count_out), 100);
    chk("nominal_lock", 32'({fh, fl, fk}), 3'b001);
    chk("single_done", 32'(done_cnt), 1);
    measure(103, 6);
    chk("high_103", 32'({fh, fl, fk}), 3'b100);
    measure(97, 6);
    chk("low_97", 32'({fh, fl, fk}), 3'b010);
    measure(102, 6);
    chk("lock_102", 32'({fh, fl, fk}), 3'b001);
    measure(98, 6);
    measure(100, 6);
    measure(101, 2);
    chk("edge_in_fall_cycle", 32'(count_out), 101);
    measure(99, 6);
    chk("back_to_back_done", 32'(done_cnt), 8);
    // abort mid-window by dropping afctrigger
    @(negedge clk);
    refclk = 1;
    pulses(10);
    trig = 0;
    @(negedge clk);
    chk("abort_idle", 32'(busy), 0);
    refclk = 0;
    divclk = 0;
    repeat (4) @(negedge clk);
    chk("abort_held_count", 32'(count_out), 99);
    // refclk already high on ARM entry: partial window must be skipped
    refclk = 1;
    repeat (2) @(negedge clk);
    trig = 1;
    repeat (2) @(negedge clk);
    chk("partial_busy", 32'(busy), 1);
    pulses(5);
    refclk = 0;
    divclk = 0;
    repeat (3) @(negedge clk);
    measure(100, 6);
    chk("partial_skipped", 32'(count_out), 100);
    // asynchronous reset mid-window
    p = done_cnt;
    @(negedge clk);
    refclk = 1;
    pulses(10);
    @(posedge clk);
    #3;
    rst = 1;
    held = '0;
    exp_q.delete();
    #1;
    chk("async_reset", 32'({count_out, fh, fl, fk, done, busy, tmo}), 0);
    @(negedge clk);
    trig = 0;
    refclk = 0;
    divclk = 0;
    repeat (2) @(negedge clk);
    rst = 0;
    repeat (10) @(negedge clk);
    chk("no_done_after_reset", 32'(done_cnt), 32'(p));
    // saturation on the 4-bit instance
    trig4 = 1;
    window(20, 6);
    k = 0;
    while (!done4 && k < 100) begin
      @(negedge clk);
      k++;
    end
    chk("ovf_done_seen", 32'(done4), 1);
    chk("ovf_count", 32'(count4), 15);
    chk("ovf_flags", 32'({fh4, fl4, fk4}), 3'b100);
    trig4 = 0;
    repeat (3) @(negedge clk);
    // ARM with refclk held low
    trig4 = 1;
`ifdef AFC_CMP_TIMEOUT_EN
    for (int i = 1; i <= 17; i++) begin
      @(negedge clk);
      if (i < 16) chk("timeout_early", 32'(tmo4), 0);
      else if (i == 16) chk("timeout_pulse", 32'(tmo4), 1);
      else begin
        chk("timeout_cleared", 32'(tmo4), 0);
        chk("timeout_idle", 32'(busy4), 0);
      end
    end
`else
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      chk("timeout_tied_low", 32'(tmo4), 0);
    end
    chk("arm_waits", 32'(busy4), 1);
`endif
    trig4 = 0;
    repeat (3) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/afc_freq_comparator.md
AFC_FREQ_COMPARATOR -- requirements
Module: afc_freq_comparator

Interface
REQ-001 The block SHALL have parameter CNT_W, default 12, the width of the divclk edge counter.
REQ-002 The block SHALL have parameter TARGET, default 100, the expected divclk rising edges per window.
REQ-003 The block SHALL have parameter TOL, default 2, the lock tolerance in counts (plus or minus).
REQ-004 The block SHALL have parameter TIMEOUT_CYC, default 1024, the clk cycles allowed for a window to open.
REQ-005 The block SHALL have these ports: clk input 1, the single clock; rst input 1, asynchronous active-high reset.
REQ-006 The block SHALL have these ports: afctrigger input 1, level enable for calibration; refclk input 1, measurement window (clk-synchronous, high = window open); divclk input 1, divided VCO clock (asynchronous to clk).
REQ-007 The block SHALL have these ports: count_out output CNT_W, last window count; freq_high output 1; freq_low output 1; freq_lock output 1; meas_done output 1, one-cycle result strobe; busy output 1; timeout output 1.

Function
REQ-008 divclk SHALL pass through a 2-flop synchronizer, then a third flop for rising-edge detection, giving divclk_rise 3 clk cycles after the input edge.
REQ-009 refclk SHALL be registered once; ref_rise/ref_fall SHALL be derived from the registered and current values.
REQ-010 The FSM SHALL have states IDLE, ARM, COUNT, COMPARE, DONE.
REQ-011 IDLE: busy=0; on afctrigger=1 go to ARM and clear the counter.
REQ-012 ARM: busy=1; on ref_rise go to COUNT.
REQ-013 COUNT: the counter SHALL increment by 1 on each divclk_rise; on ref_fall go to COMPARE; a divclk_rise in the ref_fall cycle SHALL be counted.
REQ-014 The counter SHALL saturate at all-ones; saturation SHALL set an internal ovf flag.
REQ-015 COMPARE (one cycle): register count_out. Set freq_high if ovf or count > TARGET+TOL. Else set freq_low if count < TARGET-TOL, with TARGET-TOL clamped at 0. Else set freq_lock. Exactly one of the three SHALL be 1.
REQ-016 DONE: meas_done=1 for exactly one cycle; next state ARM if afctrigger=1, else IDLE; the counter and ovf SHALL clear on leaving DONE.
REQ-017 freq_high/freq_low/freq_lock/count_out SHALL hold their values until the next COMPARE or reset.
REQ-018 If afctrigger=0 in ARM or COUNT, the FSM SHALL return to IDLE next cycle without asserting meas_done, and results SHALL be unchanged.
REQ-019 If refclk is already high on entry to ARM, counting SHALL wait for the next ref_rise; a partial window SHALL NOT be measured.
REQ-020 Comparisons SHALL use CNT_W+1-bit unsigned arithmetic so that TARGET+TOL cannot wrap.

Reset
REQ-021 On rst=1 the FSM SHALL go to IDLE asynchronously, independent of clk.
REQ-022 On rst=1 the counter, ovf, count_out, freq_high, freq_low, freq_lock, meas_done, busy and timeout SHALL be 0, and all synchronizer flops SHALL be 0.
REQ-023 Reset asserted mid-measurement SHALL discard the measurement; no meas_done SHALL follow reset release.

Configuration
REQ-024 With macro AFC_CMP_TIMEOUT_EN defined: an ARM-state cycle counter SHALL run. If it reaches TIMEOUT_CYC without ref_rise, the FSM SHALL return to IDLE and timeout SHALL pulse high for one cycle. The ARM-state cycle counter SHALL clear on every ARM entry.
REQ-025 Without AFC_CMP_TIMEOUT_EN: ARM SHALL wait indefinitely, timeout SHALL be tied 0, and no timeout counter logic SHALL exist.

Verification
REQ-026 Nominal lock: afctrigger=1, one window containing 100 divclk edges -> count_out=100, freq_lock=1, one meas_done pulse.
REQ-027 High and low: windows with 103 and 97 edges -> freq_high=1, then freq_low=1. Boundaries: 102 and 98 edges -> freq_lock=1.
REQ-028 Overflow: CNT_W=4 with 20 edges -> count_out=15, freq_high=1.
REQ-029 Abort: afctrigger dropped mid-COUNT -> IDLE next cycle, no meas_done, prior results held. Reset mid-COUNT -> all outputs 0.
REQ-030 Timeout: with AFC_CMP_TIMEOUT_EN, TIMEOUT_CYC=16, refclk held low -> timeout pulses 1 cycle at ARM cycle 16, then IDLE. Without the macro -> busy stays 1 and timeout stays 0.
REQ-031 Back-to-back: afctrigger held, three windows of 100/101/99 edges -> three meas_done pulses, each count_out exact, no edge lost or double-counted across windows.
